ft601_bist_gen: RTL

Parametrised BIST traffic generator for the FT601 write path.
- Produces bursts of pattern words on a valid/ready stream toward the FT601 write interface.
- Issues a one-cycle `wr_start` pulse before each burst.
- Supports a single run of N bursts (on the `bist_en` rising edge) or continuous bursts (`bist_en_inf` level).
- Sits between the host/register control and the FT601 write FIFO feeder.

---
 rtl/ft601_bist_pkg.sv | 17 +
 rtl/ft601_bist_pattern.sv | 65 ++++++
 rtl/ft601_bist_gen.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ft601_bist_pkg.sv
// Shared types and constants for the FT601 BIST traffic generator.
// The LFSR constants are only consumed when FT601_BIST_LFSR_EN is defined.
package ft601_bist_pkg;

   typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_e;

   // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

   localparam int BURST_WORDS_DEF = 1024;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/ft601_bist_pattern.sv
// Pattern word generator: incrementing counter, plus a 32-bit Galois LFSR
// selectable at seed time when FT601_BIST_LFSR_EN is defined.
module ft601_bist_pattern
   import ft601_bist_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              seed,
   input  logic              advance,
   input  logic              mode,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (seed)         cnt_d = '0;
      else if (advance) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

`ifdef FT601_BIST_LFSR_EN
   localparam int REP = (DATA_W + 31) / 32;

   logic [31:0]       lfsr_q, lfsr_d;
   logic              mode_q, mode_d;
   logic [REP*32-1:0] lfsr_rep;

   always_comb begin
      lfsr_d = lfsr_q;
      mode_d = mode_q;
      if (seed) begin
         lfsr_d = LFSR_SEED;
         mode_d = mode;
      end else if (advance) begin
         lfsr_d = lfsr_step(lfsr_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= LFSR_SEED;
         mode_q <= 1'b0;
      end else begin
         lfsr_q <= lfsr_d;
         mode_q <= mode_d;
      end
   end

   assign lfsr_rep = {REP{lfsr_q}};
   assign data     = mode_q ? lfsr_rep[DATA_W-1:0] : cnt_q;
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign data        = cnt_q;
`endif

endmodule

// File: rtl/ft601_bist_gen.sv
// BIST burst generator for the FT601 write path: wr_start pulse, then a burst
// of pattern words on valid/ready. Optional LFSR pattern via FT601_BIST_LFSR_EN.
module ft601_bist_gen
   import ft601_bist_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int BURST_WORDS = BURST_WORDS_DEF,
   parameter int GAP_CYCLES  = 16,
   parameter int NBURST_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                bist_en,
   input  logic                bist_en_inf,
   input  logic [NBURST_W-1:0] burst_num,
   input  logic                pattern_sel,
   output logic                wr_start,
   output logic [DATA_W-1:0]   tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                tx_last,
   output logic                busy,
   output logic                done,
   output logic [NBURST_W-1:0] bursts_sent
);

   localparam int WW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [WW-1:0]       WORD_LAST = WW'(BURST_WORDS - 1);
   localparam logic [GW-1:0]       GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [NBURST_W-1:0] NB_MAX    = '1;

   state_e              state_q, state_d;
   logic                bist_en_q;
   logic [WW-1:0]       word_q, word_d;
   logic [GW-1:0]       gap_q, gap_d;
   logic [NBURST_W-1:0] count_q, count_d;
   logic [NBURST_W-1:0] sent_q, sent_d;
   logic                inf_run_q, inf_run_d;
   logic                wr_start_q, wr_start_d;
   logic                tx_valid_q, tx_valid_d;
   logic                tx_last_q, tx_last_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                rise, hs, cont, seed;

   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      gap_d     = gap_q;
      count_d   = count_q;
      sent_d    = sent_q;
      inf_run_d = inf_run_q;
      done_d    = 1'b0;
      seed      = 1'b0;
      rise      = bist_en & ~bist_en_q;
      hs        = tx_valid_q & tx_ready;
      // An infinite-started run never falls back on the latched count.
      cont      = bist_en_inf |
                  (~inf_run_q & (({1'b0, sent_q} + 1'b1) < {1'b0, count_q}));

      case (state_q)
         IDLE: begin
            if (rise | bist_en_inf) begin
               state_d   = START;
               count_d   = (burst_num == '0) ? NBURST_W'(1) : burst_num;
               sent_d    = '0;
               inf_run_d = bist_en_inf;
               seed      = 1'b1;
            end
         end
         START: begin
            state_d = SEND;
            word_d  = '0;
         end
         SEND: begin
            if (hs) begin
               if (word_q == WORD_LAST) begin
                  sent_d = (sent_q == NB_MAX) ? sent_q : sent_q + 1'b1;
                  gap_d  = '0;
                  if (cont) state_d = (GAP_CYCLES == 0) ? START : GAP;
                  else begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  word_d = word_q + 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) state_d = START;
            else                   gap_d   = gap_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered copies of what the next state implies.
      wr_start_d = (state_d == START);
      tx_valid_d = (state_d == SEND);
      tx_last_d  = (state_d == SEND) && (word_d == WORD_LAST);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         bist_en_q  <= 1'b0;
         word_q     <= '0;
         gap_q      <= '0;
         count_q    <= '0;
         sent_q     <= '0;
         inf_run_q  <= 1'b0;
         wr_start_q <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_last_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bist_en_q  <= bist_en;
         word_q     <= word_d;
         gap_q      <= gap_d;
         count_q    <= count_d;
         sent_q     <= sent_d;
         inf_run_q  <= inf_run_d;
         wr_start_q <= wr_start_d;
         tx_valid_q <= tx_valid_d;
         tx_last_q  <= tx_last_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   ft601_bist_pattern #(.DATA_W(DATA_W)) u_pattern (
      .clk     (clk),
      .reset   (reset),
      .seed    (seed),
      .advance (hs),
      .mode    (pattern_sel),
      .data    (tx_data)
   );

   assign wr_start    = wr_start_q;
   assign tx_valid    = tx_valid_q;
   assign tx_last     = tx_last_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign bursts_sent = sent_q;

endmodule
